// File: rtl/dual_plane_injection_scheduler_if.sv
// NI-side flit handshake, plane-side output strobes and per-plane credit returns.
// master: NI and router planes; slave: the scheduler.
interface dual_plane_injection_scheduler_if #(
  parameter int VC_NUM = 2,
  parameter int FLIT_W = 64,
  parameter int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) ();
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_data;
  logic [VC_W-1:0]   in_vc;
  logic              in_head;
  logic              in_tail;
  logic [1:0]        out_valid;
  logic [FLIT_W-1:0] out_data;
  logic [VC_W-1:0]   out_vc;
  logic [VC_NUM-1:0] credit_p0;
  logic [VC_NUM-1:0] credit_p1;

  modport master (
    output in_valid, in_data, in_vc, in_head, in_tail, credit_p0, credit_p1,
    input  in_ready, out_valid, out_data, out_vc
  );

  modport slave (
    input  in_valid, in_data, in_vc, in_head, in_tail, credit_p0, credit_p1,
    output in_ready, out_valid, out_data, out_vc
  );
endinterface

// File: rtl/dual_plane_injection_scheduler.sv
// Per-packet plane pick with per-plane/VC credits; 1-cycle registered output, in_ready from credits only.
// Optional PLANE_STATS_EN adds per-plane head-flit counters (tied to 0 when undefined).
module dual_plane_injection_scheduler #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 64,
  parameter int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic clk,
  input  logic rst,
  dual_plane_injection_scheduler_if.slave bus,
  output logic        err_o,
  output logic [15:0] pkt_cnt_p0,
  output logic [15:0] pkt_cnt_p1
);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOCK_P0, LOCK_P1} state_t;

  state_t                  state;
  logic                    rr;
  logic [VC_W-1:0]         locked_vc;
  logic [CNT_W-1:0]        cnt [2][VC_NUM];
  logic [1:0][VC_NUM-1:0]  crd;
  logic [VC_W-1:0]         cur_vc;
  logic [1:0]              avail;
  logic                    sel_plane;
  logic                    dst;
  logic                    ready;
  logic                    accept;
  logic                    fwd;

  assign crd          = {bus.credit_p1, bus.credit_p0};
  assign bus.in_ready = ready;

  always_comb begin
    cur_vc = (state == IDLE) ? bus.in_vc : locked_vc;
    avail  = 2'b00;
    for (int v = 0; v < VC_NUM; v++) begin
      if (cur_vc == VC_W'(v)) begin
        avail[0] = (cnt[0][v] != '0);
        avail[1] = (cnt[1][v] != '0);
      end
    end
    sel_plane = (&avail) ? rr : avail[1];
    case (state)
      LOCK_P0: begin ready = avail[0]; dst = 1'b0; end
      LOCK_P1: begin ready = avail[1]; dst = 1'b1; end
      default: begin ready = bus.in_head ? (|avail) : 1'b1; dst = sel_plane; end
    endcase
    accept = bus.in_valid & ready;
    // Body flits arriving in IDLE are swallowed, never forwarded.
    fwd    = accept & ((state != IDLE) | bus.in_head);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr            <= 1'b0;
      locked_vc     <= '0;
      err_o         <= 1'b0;
      bus.out_valid <= 2'b00;
      bus.out_data  <= '0;
      bus.out_vc    <= '0;
      for (int p = 0; p < 2; p++)
        for (int v = 0; v < VC_NUM; v++)
          cnt[p][v] <= CNT_MAX;
    end else begin
      bus.out_valid <= 2'b00;
      if (fwd) begin
        bus.out_valid <= dst ? 2'b10 : 2'b01;
        bus.out_data  <= bus.in_data;
        bus.out_vc    <= cur_vc;
      end

      // A send and a credit on the same counter cancel out.
      for (int p = 0; p < 2; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (crd[p][v] && !(fwd && dst == 1'(p) && cur_vc == VC_W'(v))) begin
            if (cnt[p][v] == CNT_MAX) err_o <= 1'b1;
            else                      cnt[p][v] <= cnt[p][v] + CNT_ONE;
          end else if (!crd[p][v] && fwd && dst == 1'(p) && cur_vc == VC_W'(v)) begin
            cnt[p][v] <= cnt[p][v] - CNT_ONE;
          end
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.in_head) begin
              locked_vc <= bus.in_vc;
              if (&avail) rr <= ~rr;
              if (!bus.in_tail) state <= sel_plane ? LOCK_P1 : LOCK_P0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        LOCK_P0, LOCK_P1: begin
          if (accept) begin
            if (bus.in_head) err_o <= 1'b1;
            if (bus.in_tail) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLANE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_p0 <= '0;
      pkt_cnt_p1 <= '0;
    end else if (fwd && state == IDLE) begin
      if (dst) pkt_cnt_p1 <= pkt_cnt_p1 + 16'd1;
      else     pkt_cnt_p0 <= pkt_cnt_p0 + 16'd1;
    end
  end
`else
  assign pkt_cnt_p0 = '0;
  assign pkt_cnt_p1 = '0;
`endif
endmodule

// File: tb/tb_dual_plane_injection_scheduler.sv
// Vector table plus corner sequences, then random traffic against a credit/plane reference model.
module tb_dual_plane_injection_scheduler;
  localparam int VC_NUM = 2;
  localparam int BUF    = 8;
  localparam int FLIT_W = 64;
  localparam int VC_W   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_o;
  logic [15:0] pkt_cnt_p0, pkt_cnt_p1;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dual_plane_injection_scheduler_if #(.VC_NUM(VC_NUM), .FLIT_W(FLIT_W), .VC_W(VC_W)) bus ();

  dual_plane_injection_scheduler #(
    .VC_NUM(VC_NUM), .BUFFER_SIZE(BUF), .FLIT_W(FLIT_W), .VC_W(VC_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .err_o(err_o), .pkt_cnt_p0(pkt_cnt_p0), .pkt_cnt_p1(pkt_cnt_p1)
  );

  typedef struct {
    logic              v;
    logic [VC_W-1:0]   vc;
    logic              h, t;
    logic [VC_NUM-1:0] c0, c1;
    logic              rdy;
    logic [1:0]        ov;
    logic [VC_W-1:0]   ovc;
    logic              err;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic v, logic [VC_W-1:0] vc, logic h, logic t,
                              logic [1:0] c0, logic [1:0] c1, logic rdy,
                              logic [1:0] ov, logic [VC_W-1:0] ovc, logic err);
    vec_t x;
    x.v = v; x.vc = vc; x.h = h; x.t = t; x.c0 = c0; x.c1 = c1;
    x.rdy = rdy; x.ov = ov; x.ovc = ovc; x.err = err;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [VC_W-1:0] vc,
                       input logic h, input logic t, input logic [1:0] c0, input logic [1:0] c1);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_vc     = vc;
    bus.in_head   = h;
    bus.in_tail   = t;
    bus.credit_p0 = c0;
    bus.credit_p1 = c1;
  endtask

  // Called just after a posedge: drive, check in_ready, clock, check registered outputs.
  task automatic apply(input vec_t x, input string nm);
    logic [63:0] d;
    d = {$urandom, $urandom};
    drive(x.v, d, x.vc, x.h, x.t, x.c0, x.c1);
    #1;
    chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(x.rdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(x.ov));
    if (x.ov != 2'b00) begin
      chk({nm, " out_data"}, bus.out_data, d);
      chk({nm, " out_vc"}, 64'(bus.out_vc), 64'(x.ovc));
    end
    chk({nm, " err_o"}, 64'(err_o), 64'(x.err));
  endtask

  task automatic do_reset(input string nm);
    drive(1'b0, 64'h0, '0, 1'b0, 1'b0, 2'b00, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({nm, " rst out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({nm, " rst out_data"}, bus.out_data, 64'h0);
    chk({nm, " rst out_vc"}, 64'(bus.out_vc), 64'h0);
    chk({nm, " rst err_o"}, 64'(err_o), 64'h0);
    chk({nm, " rst in_ready"}, 64'(bus.in_ready), 64'h1);
    chk({nm, " rst pkt_cnt"}, {32'h0, pkt_cnt_p1, pkt_cnt_p0}, 64'h0);
  endtask

  // Reference model state
  int          cr [2][VC_NUM];
  int          lock, lvc, rr_m, pk [2];
  bit          err_m;
  logic [1:0]  e_ov;
  logic [63:0] e_d;
  logic [VC_W-1:0] e_vc;

  initial begin
    // planes go 0,1,0,1 on VC0; 3-flit VC1 packet stays on plane 0
    tbl[0]  = mk(1, 0, 1, 1, 0, 0, 1, 2'b01, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 0, 0, 1, 2'b10, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 0, 0, 1, 2'b01, 0, 0);
    tbl[3]  = mk(1, 0, 1, 1, 0, 0, 1, 2'b10, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 0, 1, 2'b01, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 1, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 0, 1, 2'b01, 1, 0);
    // 6-flit packet drains plane 1 VC0 (6 -> 0)
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1, 2'b10, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 0, 0, 1, 2'b10, 0, 0);
    // only plane 0 available: rr stays 0; plane 0 VC0 goes 6 -> 3
    tbl[13] = mk(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0);
    tbl[16] = mk(1, 1, 1, 1, 0, 0, 1, 2'b01, 1, 0);
    // rr=1 but plane 1 VC0 empty -> plane 0, rr unchanged so next tie goes to plane 1
    tbl[17] = mk(1, 0, 1, 1, 0, 0, 1, 2'b01, 0, 0);
    tbl[18] = mk(1, 1, 1, 1, 0, 0, 1, 2'b10, 1, 0);
    tbl[19] = mk(1, 0, 1, 1, 0, 0, 1, 2'b01, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0);
    tbl[22] = mk(1, 0, 1, 1, 0, 0, 1, 2'b01, 0, 0);

    do_reset("init");
    for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Exhaust plane 0 VC0 inside one locked packet, then a single credit releases one flit
    do_reset("exh");
    apply(mk(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0), "exh head");
    for (int i = 0; i < 7; i++) apply(mk(1, 1, 0, 0, 0, 0, 1, 2'b01, 0, 0), $sformatf("exh body%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "exh stall");
    apply(mk(1, 0, 0, 0, 2'b01, 0, 0, 2'b00, 0, 0), "exh credit");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "exh ninth");
    apply(mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0), "exh tail stall");

    // Simultaneous send and credit at 5 leaves 5; credit at full sets err_o
    do_reset("sim");
    apply(mk(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0), "sim head");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "sim b1");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "sim b2");
    apply(mk(1, 0, 0, 0, 2'b01, 0, 1, 2'b01, 0, 0), "sim cancel");
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), $sformatf("sim drain%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "sim empty");
    apply(mk(0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 1), "sim overflow");

    // Reset mid-packet, then a body flit in IDLE is dropped with err_o
    do_reset("mid");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1), "idle body");
    do_reset("post");
    apply(mk(1, 1, 1, 1, 0, 0, 1, 2'b01, 1, 0), "post head");

    // Randomized traffic against the reference model
    do_reset("rnd");
    for (int p = 0; p < 2; p++) begin
      pk[p] = 0;
      for (int v = 0; v < VC_NUM; v++) cr[p][v] = BUF;
    end
    lock = -1; lvc = 0; rr_m = 0; err_m = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, h, t, rdy, a0, a1;
      logic [VC_W-1:0] vcin;
      logic [1:0] c0, c1;
      logic [63:0] d;
      int cv, p;
      v    = ($urandom_range(0, 99) < 75);
      h    = (lock < 0) ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 3);
      t    = ($urandom_range(0, 99) < 30);
      vcin = VC_W'($urandom_range(0, VC_NUM - 1));
      d    = {$urandom, $urandom};
      for (int v2 = 0; v2 < VC_NUM; v2++) begin
        c0[v2] = (cr[0][v2] < BUF && $urandom_range(0, 99) < 35) || (cyc > 2800 && $urandom_range(0, 199) == 0);
        c1[v2] = (cr[1][v2] < BUF && $urandom_range(0, 99) < 35) || (cyc > 2800 && $urandom_range(0, 199) == 0);
      end
      drive(v, d, vcin, h, t, c0, c1);
      #1;
      cv  = (lock < 0) ? int'(vcin) : lvc;
      a0  = cr[0][cv] > 0;
      a1  = cr[1][cv] > 0;
      rdy = (lock < 0) ? (h ? (a0 | a1) : 1'b1) : ((lock == 0) ? a0 : a1);
      chk($sformatf("rnd%0d in_ready", cyc), 64'(bus.in_ready), 64'(rdy));

      e_ov = 2'b00;
      if (v && rdy) begin
        if (lock < 0) begin
          if (h) begin
            p = (a0 && a1) ? rr_m : (a0 ? 0 : 1);
            if (a0 && a1) rr_m ^= 1;
            lvc = cv;
            cr[p][cv]--;
            pk[p]++;
            e_ov = (p == 1) ? 2'b10 : 2'b01;
            e_d = d; e_vc = VC_W'(cv);
            if (!t) lock = p;
          end else begin
            err_m = 1;
          end
        end else begin
          p = lock;
          cr[p][lvc]--;
          e_ov = (p == 1) ? 2'b10 : 2'b01;
          e_d = d; e_vc = VC_W'(lvc);
          if (h) err_m = 1;
          if (t) lock = -1;
        end
      end
      for (int v2 = 0; v2 < VC_NUM; v2++) begin
        if (c0[v2]) begin if (cr[0][v2] >= BUF) err_m = 1; else cr[0][v2]++; end
        if (c1[v2]) begin if (cr[1][v2] >= BUF) err_m = 1; else cr[1][v2]++; end
      end

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d out_valid", cyc), 64'(bus.out_valid), 64'(e_ov));
      if (e_ov != 2'b00) begin
        chk($sformatf("rnd%0d out_data", cyc), bus.out_data, e_d);
        chk($sformatf("rnd%0d out_vc", cyc), 64'(bus.out_vc), 64'(e_vc));
      end
      chk($sformatf("rnd%0d err_o", cyc), 64'(err_o), 64'(err_m));
    end

    begin
      logic [15:0] e0, e1;
`ifdef PLANE_STATS_EN
      e0 = 16'(pk[0]);
      e1 = 16'(pk[1]);
`else
      e0 = 16'h0;
      e1 = 16'h0;
`endif
      chk("pkt_cnt_p0", 64'(pkt_cnt_p0), 64'(e0));
      chk("pkt_cnt_p1", 64'(pkt_cnt_p1), 64'(e1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dual_plane_injection_scheduler.md
Name: dual_plane_injection_scheduler

Overview:
Sits between a node's network interface and the local upstream ports of the two parallel router planes (plane 0, plane 1). It accepts one wormhole packet stream from the NI and picks a plane per packet. It tracks per-plane, per-VC downstream credits and keeps every flit of a packet on the plane chosen at the head flit. It balances load across planes with a round-robin tie-break.

Parameters:
VC_NUM, 2, virtual channels per plane
BUFFER_SIZE, 8, flit slots per VC in router input buffer; initial credit count
FLIT_W, 64, flit payload width in bits
VC_W, $clog2(VC_NUM) (min 1), VC index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  NI flit valid
in_ready  out  1  flit accepted this cycle when in_valid & in_ready
in_data  in  FLIT_W  flit
in_vc  in  VC_W  target VC; sampled on head flits only
in_head  in  1  head flit marker
in_tail  in  1  tail flit marker (head&tail = single-flit packet)
out_valid  out  2  one-hot plane strobe, bit p = plane p
out_data  out  FLIT_W  flit to selected plane
out_vc  out  VC_W  VC of flit
credit_p0  in  VC_NUM  per-VC one-cycle credit-return pulse from plane 0
credit_p1  in  VC_NUM  same, plane 1
err_o  out  1  sticky protocol error flag
pkt_cnt_p0  out  16  head flits sent to plane 0 (optional feature)
pkt_cnt_p1  out  16  head flits sent to plane 1 (optional feature)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr=0, all credit counters=BUFFER_SIZE, out_valid=0, out_data=0, out_vc=0, err_o=0, pkt counters=0. Reset mid-packet abandons the packet, with no tail sent.
- Credit counters cnt[p][v], width $clog2(BUFFER_SIZE+1):
  - accept to (p,v): -1
  - credit pulse on (p,v): +1
  - both in same cycle: unchanged
  - increment at BUFFER_SIZE saturates and sets err_o
- avail[p] = cnt[p][vc]>0, where vc = in_vc in IDLE, locked_vc otherwise.
- FSM states: IDLE, LOCK_P0, LOCK_P1.
- IDLE, head flit:
  - in_ready = avail[0]|avail[1].
  - Plane choice: only one available -> that plane; both available -> plane rr, then rr toggles.
  - On accept: latch locked_vc=in_vc. If in_tail=0 -> LOCK_Pp; if in_tail=1 -> stay IDLE.
- IDLE, non-head flit: in_ready=1, flit dropped, err_o set, no output.
- LOCK_Pp:
  - in_ready = cnt[p][locked_vc]>0; in_vc ignored.
  - Accept with in_tail -> IDLE.
  - A head flit while locked is forwarded as body, sets err_o, and the lock is kept.
- Output is registered with 1-cycle latency. A flit accepted at edge t appears on out_data/out_vc with out_valid[p]=1 during cycle t+1. out_valid=0 in any cycle without a preceding accept; out_data holds its last value.
- in_ready is combinational from state and counters only; it never depends on in_valid.
- A credit pulse at edge t is reflected in in_ready from cycle t+1.
- No internal buffering beyond the output register; the planes' local input buffers are guaranteed by credits.

Optional Feature:
PLANE_STATS_EN
- Defined: pkt_cnt_p0/p1 increment on each accepted head flit to that plane (single-flit packets included), wrap 0xFFFF->0, reset 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
1. Reset, then 4 single-flit packets on VC0, no credit returns -> planes 0,1,0,1; counters p0 and p1 VC0 at 6; out_valid one cycle after each accept.
2. 3-flit packet on VC1 (head,body,tail) while rr=0 -> all 3 flits on plane 0 with out_vc=1, state back to IDLE after tail, rr=1.
3. Exhaust plane 0 VC0 with 8 flits of one locked packet (no tail, no credits) -> in_ready=0 on 9th flit. A single credit_p0[0] pulse makes in_ready=1 the next cycle and the 9th flit goes to plane 0.
4. Plane 1 VC0 counter at 0, plane 0 at 3, head flit with rr=1 -> plane 0 chosen, rr unchanged.
5. Accept on (0,0) in the same cycle as credit_p0[0] pulse with counter at 5 -> counter stays 5. Credit pulse with counter at 8 -> stays 8, err_o=1.
6. Body flit in IDLE -> consumed, out_valid stays 0, err_o=1. Assert rst mid-packet -> state IDLE, credits 8, err_o=0.
